// File: rtl/pc_isp_if.sv
// Prefetch-facing bundle for the program counter / return-address stack.
// The prefetch stage is the master: it issues loads and calls and receives the PC and stack status.
interface pc_isp_if #(
    parameter int MINSTW = 8,
    parameter int SPW    = 3
);
    logic              en;
    logic              pc_load;
    logic              isp_push;
    logic              isp_pop;
    logic [MINSTW-1:0] load_addr;
    logic              clr_err;
    logic [MINSTW-1:0] addr;
    logic [SPW:0]      depth;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output en, pc_load, isp_push, isp_pop, load_addr, clr_err,
        input  addr, depth, stk_full, stk_empty, stk_ovf, stk_unf
    );

    modport slave (
        input  en, pc_load, isp_push, isp_pop, load_addr, clr_err,
        output addr, depth, stk_full, stk_empty, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_isp.sv
// Program counter with return-address stack: sequential advance, jump, call/return,
// and sticky overflow/underflow flags.
module pc_isp #(
    parameter int MINSTW = 8,
    parameter int SDEPTH = 8,
    parameter int SPW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    pc_isp_if.slave    bus
);

    logic [MINSTW-1:0] addr_q;
    logic [MINSTW-1:0] addr_nxt;
    logic [MINSTW-1:0] addr_inc;
    logic [MINSTW-1:0] top;
    logic [SPW:0]      depth_q;
    logic [SPW:0]      depth_nxt;
    logic [MINSTW-1:0] stack_mem [SDEPTH];
    logic [SPW-1:0]    top_idx;
    logic [SPW-1:0]    push_idx;
    logic              empty;
    logic              full;
    logic              ret_req;
    logic              call_req;
    logic              do_pop;
    logic              do_push;
    logic              do_swap;
    logic              unf_evt;
    logic              ovf_evt;
    logic              ovf_q;
    logic              unf_q;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == (SPW+1)'(SDEPTH));
    assign addr_inc = addr_q + 1'b1;
    assign top_idx  = SPW'(depth_q - 1'b1);
    assign push_idx = depth_q[SPW-1:0];
    assign top      = stack_mem[top_idx];

    // Stack operations only count when qualified by pc_load.
    assign ret_req  = bus.pc_load & bus.isp_pop;
    assign call_req = bus.pc_load & bus.isp_push & ~bus.isp_pop;
    assign do_pop   = ret_req & ~bus.isp_push & ~empty;
    assign do_swap  = ret_req & bus.isp_push & ~empty;
    assign unf_evt  = ret_req & empty;
    assign do_push  = call_req & ~full;
    assign ovf_evt  = call_req & full;

    always_comb begin
        addr_nxt = addr_inc;
        if (ret_req && !empty)
            addr_nxt = top;
        else if (bus.pc_load && !bus.isp_pop)
            addr_nxt = bus.load_addr;
    end

    always_comb begin
        depth_nxt = depth_q;
        if (do_push)
            depth_nxt = depth_q + 1'b1;
        else if (do_pop)
            depth_nxt = depth_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            depth_q <= '0;
        end else if (bus.en) begin
            addr_q  <= addr_nxt;
            depth_q <= depth_nxt;
        end
    end

    // clr_err is honoured even while stalled; a same-cycle set wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~bus.clr_err) | (bus.en & ovf_evt);
            unf_q <= (unf_q & ~bus.clr_err) | (bus.en & unf_evt);
        end
    end

    // Stack storage has no reset; depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            if (do_push)
                stack_mem[push_idx] <= addr_inc;
            else if (do_swap)
                stack_mem[top_idx] <= addr_inc;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.depth     = depth_q;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_unf   = unf_q;

endmodule
